muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings and controller state encoding for the multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDiv  = 2'b10,
        StFix  = 2'b11
    } state_e;

    // MULT and DIV (op[0] == 0) treat operands as two's complement.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// sharing one {acc, q} shift register. Signs are stripped on entry and restored in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PQ_W  = 2 * WIDTH + 1;

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    // Upper WIDTH+1 bits: accumulator / partial remainder; lower WIDTH: multiplier / quotient.
    logic [PQ_W-1:0]    pq_q;
    logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic               is_div_q;
    logic               neg_lo_q;    // negate product / quotient in FIX
    logic               neg_hi_q;    // negate remainder in FIX
    logic               dz_q;

    logic               sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum, sub_diff;
    logic [PQ_W-1:0]    shl, pq_step;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign busy = (state_q != StIdle);

    // Operand magnitudes for the entry cycle.
    always_comb begin
        sgn   = op_is_signed(op);
        a_mag = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    end

    // One iteration step of the shared datapath, plus the sign-corrected results.
    always_comb begin
        add_sum  = pq_q[PQ_W-1:WIDTH] + (pq_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        shl      = {pq_q[PQ_W-2:0], 1'b0};
        sub_diff = shl[PQ_W-1:WIDTH] - {1'b0, opnd_q};
        if (state_q == StMul) begin
            pq_step = {1'b0, add_sum, pq_q[WIDTH-1:1]};
        end else if (!sub_diff[WIDTH]) begin
            pq_step = {sub_diff, shl[WIDTH-1:1], 1'b1};
        end else begin
            pq_step = shl;
        end
        prod     = pq_q[2*WIDTH-1:0];
        prod_fix = neg_lo_q ? -prod : prod;
        // With a zero divisor every trial subtract succeeds, leaving |a| as the remainder.
        quo_fix  = dz_q ? {WIDTH{1'b1}} :
                   (neg_lo_q ? -pq_q[WIDTH-1:0] : pq_q[WIDTH-1:0]);
        rem_fix  = neg_hi_q ? -pq_q[2*WIDTH-1:WIDTH] : pq_q[2*WIDTH-1:WIDTH];
    end

    // Controller FSM, working registers and HI/LO with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            pq_q        <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            dz_q        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start && !cancel) begin
                        pq_q     <= {{(WIDTH+1){1'b0}}, a_mag};
                        opnd_q   <= b_mag;
                        count_q  <= CNT_W'(WIDTH - 1);
                        is_div_q <= op_is_div(op);
                        neg_lo_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_q <= sgn & a[WIDTH-1];
                        dz_q     <= op_is_div(op) & (b == '0);
                        state_q  <= op_is_div(op) ? StDiv : StMul;
                    end
                end
                StMul, StDiv: begin
                    if (cancel) begin
                        state_q <= StIdle;
                    end else begin
                        pq_q    <= pq_step;
                        count_q <= count_q - CNT_W'(1);
                        if (count_q == '0) state_q <= StFix;
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    if (!cancel) begin
                        if (is_div_q) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done        <= 1'b1;
                        div_by_zero <= is_div_q & dz_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // WIDTH=32 instance
    logic        s_start, s_cancel, s_mthi, s_mtlo;
    logic [1:0]  s_op;
    logic [31:0] s_a, s_b, s_wdata;
    logic        s_busy, s_done, s_dz;
    logic [31:0] s_hi, s_lo;
    // WIDTH=8 instance
    logic        e_start, e_cancel, e_mthi, e_mtlo;
    logic [1:0]  e_op;
    logic [7:0]  e_a, e_b, e_wdata;
    logic        e_busy, e_done, e_dz;
    logic [7:0]  e_hi, e_lo;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .cancel(s_cancel), .mthi(s_mthi), .mtlo(s_mtlo), .wdata(s_wdata),
        .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo), .div_by_zero(s_dz)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(e_start), .op(e_op), .a(e_a), .b(e_b),
        .cancel(e_cancel), .mthi(e_mthi), .mtlo(e_mtlo), .wdata(e_wdata),
        .busy(e_busy), .done(e_done), .hi(e_hi), .lo(e_lo), .div_by_zero(e_dz)
    );

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain wide integer arithmetic, masked to w bits.
    function automatic exp_t model(input int w, input logic [1:0] o,
                                   input logic [63:0] x, input logic [63:0] y);
        exp_t        r;
        logic [63:0] mask, ux, uy, up, uq, ur;
        longint      sx, sy, sp;
        mask = (64'd1 << w) - 64'd1;
        ux = x & mask;
        uy = y & mask;
        sx = $signed(ux << (64 - w));
        sx = sx >>> (64 - w);
        sy = $signed(uy << (64 - w));
        sy = sy >>> (64 - w);
        r.dz = 1'b0;
        up = '0; uq = '0; ur = '0;
        case (o)
            2'b00: begin sp = sx * sy; up = sp; end
            2'b01: up = ux * uy;
            2'b10: begin
                if (uy == 0) begin r.dz = 1'b1; uq = mask; ur = ux; end
                else begin sp = sx / sy; uq = sp; sp = sx % sy; ur = sp; end
            end
            default: begin
                if (uy == 0) begin r.dz = 1'b1; uq = mask; ur = ux; end
                else begin uq = ux / uy; ur = ux % uy; end
            end
        endcase
        if (o[1]) begin
            r.hi = ur & mask;
            r.lo = uq & mask;
        end else begin
            r.hi = (up >> w) & mask;
            r.lo = up & mask;
        end
        return r;
    endfunction

    // Issue one op on the 32-bit unit and wait (bounded) for done. lat = -1 on timeout.
    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl, output logic rz,
                         output int lat, output int bc);
        s_op = o; s_a = x; s_b = y; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        lat = -1; bc = s_busy ? 1 : 0; rh = '0; rl = '0; rz = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (s_done) begin
                lat = i; rh = s_hi; rl = s_lo; rz = s_dz;
                break;
            end
            if (s_busy) bc++;
        end
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] rh, output logic [7:0] rl, output logic rz,
                        output int lat);
        e_op = o; e_a = x; e_b = y; e_start = 1'b1;
        tick();
        e_start = 1'b0;
        lat = -1; rh = '0; rl = '0; rz = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (e_done) begin
                lat = i; rh = e_hi; rl = e_lo; rz = e_dz;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_mthi = 1'b1; s_wdata = 32'hFFFF_0000;
        tick(); tick();
        s_mthi = 1'b0;
        rst = 1'b0;
        n_checks++; if (s_busy !== 1'b0) $display("FAIL reset busy: got %b want 0", s_busy); else n_pass++;
        n_checks++; if (s_done !== 1'b0) $display("FAIL reset done: got %b want 0", s_done); else n_pass++;
        n_checks++; if (s_hi !== 32'h0) $display("FAIL reset hi: got %h want 0", s_hi); else n_pass++;
        n_checks++; if (s_lo !== 32'h0) $display("FAIL reset lo: got %h want 0", s_lo); else n_pass++;
        n_checks++; if (s_dz !== 1'b0) $display("FAIL reset dz: got %b want 0", s_dz); else n_pass++;
        n_checks++; if (e_busy !== 1'b0 || e_hi !== 8'h0 || e_lo !== 8'h0)
            $display("FAIL reset w8: busy %b hi %h lo %h want 0", e_busy, e_hi, e_lo); else n_pass++;
    endtask

    task automatic test_mult();
        logic [31:0] rh, rl; logic rz; int lat, bc; exp_t e;
        sb.push_back('{hi: 64'hFFFF_FFFF, lo: 64'hFFFF_FFF1, dz: 1'b0});
        run32(2'b00, 32'hFFFF_FFFD, 32'd5, rh, rl, rz, lat, bc);
        e = sb.pop_front();
        n_checks++; if (rh !== e.hi[31:0]) $display("FAIL mult hi: got %h want %h", rh, e.hi[31:0]); else n_pass++;
        n_checks++; if (rl !== e.lo[31:0]) $display("FAIL mult lo: got %h want %h", rl, e.lo[31:0]); else n_pass++;
        // Sampling edge counted as edge 1, so done lands on edge 34.
        n_checks++; if (lat + 1 !== 34) $display("FAIL mult done edge: got %0d want 34", lat + 1); else n_pass++;
        n_checks++; if (bc !== 33) $display("FAIL mult busy cycles: got %0d want 33", bc); else n_pass++;
        tick();
        n_checks++; if (s_done !== 1'b0) $display("FAIL mult done width: got %b want 0", s_done); else n_pass++;
    endtask

    task automatic test_div();
        logic [1:0]  vo[4];
        logic [31:0] va[4], vb[4], vh[4], vl[4];
        logic        vz[4];
        logic [31:0] rh, rl; logic rz; int lat, bc; exp_t e;
        vo[0] = 2'b11; va[0] = 32'd100;        vb[0] = 32'd7;          vh[0] = 32'd2;          vl[0] = 32'd14;         vz[0] = 1'b0;
        vo[1] = 2'b10; va[1] = 32'hFFFF_FFF9;  vb[1] = 32'd2;          vh[1] = 32'hFFFF_FFFF;  vl[1] = 32'hFFFF_FFFD;  vz[1] = 1'b0;
        vo[2] = 2'b10; va[2] = 32'h8000_0000;  vb[2] = 32'hFFFF_FFFF;  vh[2] = 32'h0;          vl[2] = 32'h8000_0000;  vz[2] = 1'b0;
        vo[3] = 2'b11; va[3] = 32'd5;          vb[3] = 32'd0;          vh[3] = 32'd5;          vl[3] = 32'hFFFF_FFFF;  vz[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{hi: {32'h0, vh[i]}, lo: {32'h0, vl[i]}, dz: vz[i]});
            run32(vo[i], va[i], vb[i], rh, rl, rz, lat, bc);
            e = sb.pop_front();
            n_checks++; if (rl !== e.lo[31:0]) $display("FAIL div%0d lo: got %h want %h", i, rl, e.lo[31:0]); else n_pass++;
            n_checks++; if (rh !== e.hi[31:0]) $display("FAIL div%0d hi: got %h want %h", i, rh, e.hi[31:0]); else n_pass++;
            n_checks++; if (rz !== e.dz) $display("FAIL div%0d dz: got %b want %b", i, rz, e.dz); else n_pass++;
            n_checks++; if (lat !== 33) $display("FAIL div%0d latency: got %0d want 33", i, lat); else n_pass++;
        end
    endtask

    task automatic test_cancel();
        bit seen;
        s_wdata = 32'h1234; s_mthi = 1'b1; tick(); s_mthi = 1'b0;
        s_wdata = 32'h5678; s_mtlo = 1'b1; tick(); s_mtlo = 1'b0;
        s_op = 2'b01; s_a = 32'd3; s_b = 32'd4; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        s_cancel = 1'b1;
        tick();
        s_cancel = 1'b0;
        n_checks++; if (s_busy !== 1'b0) $display("FAIL cancel busy: got %b want 0", s_busy); else n_pass++;
        seen = s_done;
        for (int i = 0; i < 40; i++) begin tick(); if (s_done) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) $display("FAIL cancel done: got 1 want 0"); else n_pass++;
        n_checks++; if (s_hi !== 32'h1234) $display("FAIL cancel hi: got %h want 1234", s_hi); else n_pass++;
        n_checks++; if (s_lo !== 32'h5678) $display("FAIL cancel lo: got %h want 5678", s_lo); else n_pass++;
        // cancel coinciding with start in IDLE suppresses the start
        s_start = 1'b1; s_cancel = 1'b1;
        tick();
        s_start = 1'b0; s_cancel = 1'b0;
        n_checks++; if (s_busy !== 1'b0) $display("FAIL cancel+start busy: got %b want 0", s_busy); else n_pass++;
    endtask

    task automatic test_mt();
        logic [31:0] rh, rl; logic rz; int lat, bc; exp_t e;
        s_wdata = 32'h9; s_mthi = 1'b1; s_mtlo = 1'b1;
        tick();
        s_mthi = 1'b0; s_mtlo = 1'b0;
        n_checks++; if (s_hi !== 32'h9 || s_lo !== 32'h9)
            $display("FAIL mthi+mtlo: got hi %h lo %h want 9 9", s_hi, s_lo); else n_pass++;
        // mthi together with start: the write lands, then the result overwrites it
        s_wdata = 32'hAAAA; s_mthi = 1'b1;
        s_op = 2'b01; s_a = 32'd2; s_b = 32'd3; s_start = 1'b1;
        tick();
        s_mthi = 1'b0; s_start = 1'b0;
        n_checks++; if (s_hi !== 32'hAAAA) $display("FAIL mthi with start: got %h want aaaa", s_hi); else n_pass++;
        sb.push_back('{hi: 64'h0, lo: 64'h6, dz: 1'b0});
        lat = -1;
        for (int i = 1; i <= 100; i++) begin tick(); if (s_done) begin lat = i; break; end end
        e = sb.pop_front();
        n_checks++; if (lat < 0 || s_hi !== e.hi[31:0] || s_lo !== e.lo[31:0])
            $display("FAIL mt overwrite: lat %0d hi %h lo %h want hi %h lo %h",
                     lat, s_hi, s_lo, e.hi[31:0], e.lo[31:0]); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int lat; exp_t e;
        sb.push_back('{hi: 64'h0, lo: 64'd42, dz: 1'b0});
        s_op = 2'b01; s_a = 32'd6; s_b = 32'd7; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick(); tick();
        s_op = 2'b00; s_a = 32'd1000; s_b = 32'd1000; s_start = 1'b1;
        s_wdata = 32'hDEAD; s_mthi = 1'b1; s_mtlo = 1'b1;
        tick();
        s_start = 1'b0; s_mthi = 1'b0; s_mtlo = 1'b0;
        n_checks++; if (s_hi !== 32'h0 || s_lo !== 32'd6)
            $display("FAIL mt while busy: got hi %h lo %h want 0 6", s_hi, s_lo); else n_pass++;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin tick(); if (s_done) begin lat = i; break; end end
        e = sb.pop_front();
        n_checks++; if (lat < 0 || s_hi !== e.hi[31:0] || s_lo !== e.lo[31:0])
            $display("FAIL busy ignore result: lat %0d hi %h lo %h want hi %h lo %h",
                     lat, s_hi, s_lo, e.hi[31:0], e.lo[31:0]); else n_pass++;
        tick();
        n_checks++; if (s_busy !== 1'b0) $display("FAIL start queued: busy %b want 0", s_busy); else n_pass++;
    endtask

    task automatic test_rst_mid();
        bit seen;
        s_op = 2'b10; s_a = 32'd77; s_b = 32'd5; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1; s_cancel = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++; if (s_busy !== 1'b0 || s_done !== 1'b0 || s_hi !== 32'h0 || s_lo !== 32'h0 || s_dz !== 1'b0)
            $display("FAIL rst mid-op: busy %b done %b hi %h lo %h dz %b want all 0",
                     s_busy, s_done, s_hi, s_lo, s_dz); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin tick(); if (s_done) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) $display("FAIL rst mid-op done: got 1 want 0"); else n_pass++;
    endtask

    task automatic test_w8();
        logic [7:0] rh, rl, x, y; logic [1:0] o; logic rz; int lat, bad; exp_t e;
        sb.push_back('{hi: 64'h40, lo: 64'h00, dz: 1'b0});
        run8(2'b00, 8'h80, 8'h80, rh, rl, rz, lat);
        e = sb.pop_front();
        n_checks++; if ({rh, rl} !== {e.hi[7:0], e.lo[7:0]})
            $display("FAIL w8 min*min: got %h want %h", {rh, rl}, {e.hi[7:0], e.lo[7:0]}); else n_pass++;
        n_checks++; if (lat + 1 !== 10) $display("FAIL w8 done edge: got %0d want 10", lat + 1); else n_pass++;
        bad = 0;
        for (int n = 0; n < 3000; n++) begin
            o = 2'($urandom_range(0, 3));
            x = 8'($urandom);
            y = 8'($urandom);
            case ($urandom_range(0, 15))
                0: y = 8'h00;
                1: begin x = 8'h80; y = 8'hFF; end
                default: ;
            endcase
            sb.push_back(model(8, o, {56'h0, x}, {56'h0, y}));
            run8(o, x, y, rh, rl, rz, lat);
            e = sb.pop_front();
            n_checks++;
            if (lat !== 9 || rh !== e.hi[7:0] || rl !== e.lo[7:0] || rz !== e.dz) begin
                bad++;
                if (bad <= 10)
                    $display("FAIL w8 random op %0d a %h b %h: got hi %h lo %h dz %b lat %0d want hi %h lo %h dz %b lat 9",
                             o, x, y, rh, rl, rz, lat, e.hi[7:0], e.lo[7:0], e.dz);
            end else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        s_start = 0; s_cancel = 0; s_mthi = 0; s_mtlo = 0; s_op = 0; s_a = 0; s_b = 0; s_wdata = 0;
        e_start = 0; e_cancel = 0; e_mthi = 0; e_mtlo = 0; e_op = 0; e_a = 0; e_b = 0; e_wdata = 0;
        tick();
        test_reset();
        test_mult();
        test_div();
        test_cancel();
        test_mt();
        test_busy_ignore();
        test_rst_mid();
        test_w8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
